// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imm_pkg
//  Purpose  : Shared types and field constants for the immediate encoder.
//  Revision : 1.0  initial release
// ============================================================================
package imm_pkg;

    // Codes match the decoder's imm_control encoding; 110/111 are reserved
    typedef enum logic [2:0] {
        FMT_I   = 3'b000,
        FMT_S   = 3'b001,
        FMT_U   = 3'b010,
        FMT_B   = 3'b011,
        FMT_J   = 3'b100,
        FMT_CSR = 3'b101
    } imm_fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Instruction bit positions owned by each immediate format
    localparam logic [31:0] C_MASK_I = 32'hFFF0_0000;
    localparam logic [31:0] C_MASK_S = 32'hFE00_0F80;
    localparam logic [31:0] C_MASK_U = 32'hFFFF_F000;
    localparam logic [31:0] C_MASK_B = 32'hFE00_0F80;
    localparam logic [31:0] C_MASK_J = 32'hFFFF_F000;

    // Bits [31:msb] that must all match for a value to fit signed in msb+1 bits
    localparam logic [31:0] C_SEXT_12 = 32'hFFFF_F800;
    localparam logic [31:0] C_SEXT_13 = 32'hFFFF_F000;
    localparam logic [31:0] C_SEXT_21 = 32'hFFF0_0000;

    function automatic logic fits_signed(input logic [31:0] v, input logic [31:0] m);
        return ((v & m) == 32'd0) || ((v & m) == m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_encoder_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : imm_encoder_loader_if
//  Purpose  : Input-word and memory-write handshake bundle for the loader.
//  Revision : 1.0  initial release
// ============================================================================
interface imm_encoder_loader_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_base;
    logic [31:0]       in_imm;
    logic [2:0]        in_fmt;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, in_base, in_imm, in_fmt, in_last, out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );

    modport slave (
        input  in_valid, in_base, in_imm, in_fmt, in_last, out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );
endinterface
`default_nettype wire

// File: rtl/imm_scatter.sv
`default_nettype none
// ============================================================================
//  Module   : imm_scatter
//  Purpose  : Combinational immediate range check and bit scatter into a word.
//  Revision : 1.0  initial release
// ============================================================================
module imm_scatter
    import imm_pkg::*;
(
    input  wire logic [31:0] in_base,
    input  wire logic [31:0] in_imm,
    input  wire logic [2:0]  in_fmt,
    output logic      [31:0] encoded,
    output logic             range_ok
);

    always_comb begin
        encoded  = in_base;
        range_ok = 1'b0;
        case (in_fmt)
            FMT_I: begin
                encoded  = (in_base & ~C_MASK_I) | {in_imm[11:0], 20'd0};
                range_ok = fits_signed(in_imm, C_SEXT_12);
            end
            FMT_CSR: begin
                encoded  = (in_base & ~C_MASK_I) | {in_imm[11:0], 20'd0};
                range_ok = (in_imm[31:12] == 20'd0);
            end
            FMT_S: begin
                encoded  = (in_base & ~C_MASK_S)
                         | {in_imm[11:5], 13'd0, in_imm[4:0], 7'd0};
                range_ok = fits_signed(in_imm, C_SEXT_12);
            end
            FMT_U: begin
                encoded  = (in_base & ~C_MASK_U) | {in_imm[31:12], 12'd0};
                range_ok = (in_imm[11:0] == 12'd0);
            end
            FMT_B: begin
                encoded  = (in_base & ~C_MASK_B)
                         | {in_imm[12], in_imm[10:5], 13'd0, in_imm[4:1], in_imm[11], 7'd0};
                range_ok = fits_signed(in_imm, C_SEXT_13) && !in_imm[0];
            end
            FMT_J: begin
                encoded  = (in_base & ~C_MASK_J)
                         | {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], 12'd0};
                range_ok = fits_signed(in_imm, C_SEXT_21) && !in_imm[0];
            end
            default: begin
                encoded  = in_base;
                range_ok = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_encoder_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imm_encoder_loader
//  Purpose  : Encodes immediates into instruction words and streams them to
//             instruction memory with sequencing, backpressure and status.
//  Revision : 1.0  initial release
// ============================================================================
module imm_encoder_loader
    import imm_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MAX_WORDS = 256
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    input  wire logic [ADDR_W-1:0] base_addr,
    imm_encoder_loader_if.slave    bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic      [7:0]        err_count
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_addr_cnt;
    logic [CNT_W-1:0]  r_word_cnt;
    logic              r_out_valid;
    logic [31:0]       r_out_instr;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_err;
    logic [7:0]        r_err_count;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_start_ok;
    logic              w_final;
    logic [31:0]       w_encoded;
    logic              w_range_ok;

    imm_scatter u_scatter (
        .in_base  (bus.in_base),
        .in_imm   (bus.in_imm),
        .in_fmt   (bus.in_fmt),
        .encoded  (w_encoded),
        .range_ok (w_range_ok)
    );

    assign w_in_ready = (r_state == ST_RUN) && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    // The accept that brings the word count up to MAX_WORDS closes the program
    assign w_final    = bus.in_last || (r_word_cnt == CNT_W'(MAX_WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_accept && w_final) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!r_out_valid || bus.out_ready) w_state_nxt = ST_DONE;
            ST_DONE:  if (start) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_cnt  <= '0;
            r_word_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_instr <= 32'd0;
            r_out_addr  <= '0;
            r_err       <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            if (w_start_ok) begin
                r_addr_cnt  <= {base_addr[ADDR_W-1:2], 2'b00};
                r_word_cnt  <= '0;
                r_err       <= 1'b0;
                r_err_count <= 8'd0;
            end

            if (w_accept && w_range_ok) begin
                r_out_valid <= 1'b1;
                r_out_instr <= w_encoded;
                r_out_addr  <= r_addr_cnt;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
                if (w_range_ok) begin
                    r_addr_cnt <= r_addr_cnt + ADDR_W'(4);
                end else begin
                    r_err <= 1'b1;
                    if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_instr = r_out_instr;
    assign bus.out_addr  = r_out_addr;
    assign busy          = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done          = (r_state == ST_DONE);
    assign err           = r_err;
    assign err_count     = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_encoder_loader
//  Purpose  : Directed scoreboard bench for imm_encoder_loader (MAX_WORDS=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_imm_encoder_loader;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  err_count;

    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    exp_t        sb[$];
    int          ret_cyc[$];
    logic [31:0] exp_addr;

    imm_encoder_loader_if #(.ADDR_W(32)) bus ();

    imm_encoder_loader #(.ADDR_W(32), .MAX_WORDS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Retire monitor: every handshaken output word must match the queue head
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            ret_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexpected_out", {32'd0, bus.out_instr}, 64'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_instr", {32'd0, bus.out_instr}, {32'd0, e.instr});
                chk("out_addr",  {32'd0, bus.out_addr},  {32'd0, e.addr});
            end
        end
    end

    task automatic pulse_start(input logic [31:0] b);
        base_addr = b;
        start     = 1'b1;
        exp_addr  = {b[31:2], 2'b00};
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic drive(input logic [31:0] base, input logic [31:0] imm,
                         input logic [2:0] fmt, input logic last);
        bus.in_base  = base;
        bus.in_imm   = imm;
        bus.in_fmt   = fmt;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
    endtask

    // Leaves in_valid asserted so consecutive calls stream without bubbles
    task automatic send(input logic [31:0] base, input logic [31:0] imm,
                        input logic [2:0] fmt, input logic last,
                        input logic good, input logic [31:0] exp_instr);
        int n;
        drive(base, imm, fmt, last);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.in_ready !== 1'b1 && n < 40);
        chk("accept_wait", {63'd0, bus.in_ready}, 64'd1);
        if (good) begin
            sb.push_back({exp_instr, exp_addr});
            exp_addr = exp_addr + 32'd4;
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("done", {63'd0, done}, 64'd1);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        base_addr     = 32'd0;
        bus.in_valid  = 1'b0;
        bus.in_base   = 32'd0;
        bus.in_imm    = 32'd0;
        bus.in_fmt    = 3'd0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        exp_addr      = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  {63'd0, bus.in_ready},  64'd0);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_instr", {32'd0, bus.out_instr}, 64'd0);
        chk("rst_out_addr",  {32'd0, bus.out_addr},  64'd0);
        chk("rst_busy",      {63'd0, busy},          64'd0);
        chk("rst_done",      {63'd0, done},          64'd0);
        chk("rst_err",       {63'd0, err},           64'd0);
        chk("rst_err_count", {56'd0, err_count},     64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single I word, all-ones immediate
        pulse_start(32'h100);
        chk("busy_run", {63'd0, busy}, 64'd1);
        send(32'h0000_0093, 32'hFFFF_FFFF, 3'b000, 1'b1, 1'b1, 32'hFFF0_0093);
        bus.in_valid = 1'b0;
        wait_done();

        // S, B, J streamed back to back
        pulse_start(32'h100);
        ret_cyc.delete();
        send(32'h0020_A023, 32'd8,          3'b001, 1'b0, 1'b1, 32'h0020_A423);
        send(32'h0000_0063, 32'hFFFF_FFFC,  3'b011, 1'b0, 1'b1, 32'hFE00_0EE3);
        send(32'h0000_00EF, 32'h0000_0800,  3'b100, 1'b1, 1'b1, 32'h0010_00EF);
        bus.in_valid = 1'b0;
        wait_done();
        chk("b2b_count", 64'(ret_cyc.size()), 64'd3);
        if (ret_cyc.size() == 3) chk("b2b_span", 64'(ret_cyc[2] - ret_cyc[0]), 64'd2);

        // Rejects leave the address alone; base low bits are dropped
        pulse_start(32'h203);
        send(32'h0000_0063, 32'd3,    3'b011, 1'b0, 1'b0, 32'd0);
        send(32'h0000_0013, 32'd5000, 3'b000, 1'b0, 1'b0, 32'd0);
        send(32'h0000_0013, 32'd0,    3'b110, 1'b0, 1'b0, 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rej_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rej_err",       {63'd0, err},           64'd1);
        chk("rej_err_count", {56'd0, err_count},     64'd3);
        @(posedge clk); #1;
        send(32'h0000_0013, 32'd5, 3'b000, 1'b1, 1'b1, 32'h0050_0013);
        bus.in_valid = 1'b0;
        wait_done();

        // Backpressure: held word stays stable and nothing else is accepted
        pulse_start(32'h300);
        bus.out_ready = 1'b0;
        send(32'h0000_0013, 32'd1, 3'b000, 1'b0, 1'b1, 32'h0010_0013);
        drive(32'h0000_0013, 32'd2, 3'b000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready",  {63'd0, bus.in_ready},  64'd0);
            chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("bp_out_instr", {32'd0, bus.out_instr}, 64'h0010_0013);
            chk("bp_out_addr",  {32'd0, bus.out_addr},  64'h300);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        send(32'h0000_0013, 32'd2, 3'b000, 1'b1, 1'b1, 32'h0020_0013);
        bus.in_valid = 1'b0;
        wait_done();

        // Word limit without in_last; a reject still counts toward it
        pulse_start(32'h400);
        send(32'h0000_0013, 32'd1, 3'b000, 1'b0, 1'b1, 32'h0010_0013);
        send(32'h0000_0013, 32'd1, 3'b111, 1'b0, 1'b0, 32'd0);
        send(32'h0000_0013, 32'd2, 3'b000, 1'b0, 1'b1, 32'h0020_0013);
        send(32'h0000_0013, 32'd3, 3'b000, 1'b0, 1'b1, 32'h0030_0013);
        drive(32'h0000_0013, 32'd4, 3'b000, 1'b0);
        @(negedge clk);
        chk("max_in_ready", {63'd0, bus.in_ready}, 64'd0);
        wait_done();
        chk("max_err",       {63'd0, err},       64'd1);
        chk("max_err_count", {56'd0, err_count}, 64'd1);
        bus.in_valid = 1'b0;
        pulse_start(32'h500);
        chk("restart_done",      {63'd0, done},      64'd0);
        chk("restart_err",       {63'd0, err},       64'd0);
        chk("restart_err_count", {56'd0, err_count}, 64'd0);

        // Asynchronous reset while a word is held
        bus.out_ready = 1'b0;
        send(32'h0000_0013, 32'd7, 3'b000, 1'b0, 1'b1, 32'h0070_0013);
        @(negedge clk);
        chk("pre_rst_out_valid", {63'd0, bus.out_valid}, 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("mid_rst_out_instr", {32'd0, bus.out_instr}, 64'd0);
        chk("mid_rst_out_addr",  {32'd0, bus.out_addr},  64'd0);
        chk("mid_rst_busy",      {63'd0, busy},          64'd0);
        chk("mid_rst_in_ready",  {63'd0, bus.in_ready},  64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        bus.in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
